// File: rtl/fp_single_divider.sv
// fp_single_divider: sequential IEEE-754 single-precision divider, res = op1 / op2.
// The quotient mantissa comes from a 26-step bit-serial restoring division.
// Special operands, overflow and underflow are handled when the result is packed.
// Optional feature macro: FP_SINGLE_DIVIDER_RNE_EN selects round-to-nearest-even.
// Without it the quotient is truncated toward zero. Latency is the same either way.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   ready - start strobe, sampled only while idle
//   op1   - dividend (IEEE-754 single)
//   op2   - divisor (IEEE-754 single)
//   res   - quotient, valid while done=1 and held afterwards
//   done  - one-cycle result-valid pulse
//   busy  - high from the cycle after acceptance through the done cycle
module fp_single_divider #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done,
    output logic        busy
);

    localparam int unsigned FW   = 23;       // stored fraction bits
    localparam int unsigned MW   = FW + 1;   // mantissa with hidden one
    localparam int unsigned RW   = MW + 1;   // partial remainder
    localparam int unsigned QW   = 26;       // quotient bits
    localparam int unsigned EW   = 10;       // signed working exponent
    localparam int unsigned CW   = 5;        // iteration counter
    localparam int unsigned ITER = 26;
    localparam int unsigned BIAS = 127;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] PACK   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state, state_nxt;
    logic [31:0]          a_q, a_nxt, b_q, b_nxt;
    logic                 sign_q, sign_nxt;
    logic signed [EW-1:0] exp_q, exp_nxt;
    logic [RW-1:0]        rem_q, rem_nxt;
    logic [MW-1:0]        div_q, div_nxt;
    logic [QW-1:0]        q_q, q_nxt;
    logic [CW-1:0]        cnt_q, cnt_nxt;
    logic [31:0]          res_nxt;
    logic                 done_nxt, busy_nxt;

    // Operand decode of the latched operands; denormals count as zero
    logic [7:0]    e1_c, e2_c;
    logic [FW-1:0] f1_c, f2_c;
    logic          s_c, z1_c, z2_c, i1_c, i2_c, n1_c, n2_c;

    assign s_c  = a_q[31] ^ b_q[31];
    assign e1_c = a_q[30:23];
    assign e2_c = b_q[30:23];
    assign f1_c = a_q[FW-1:0];
    assign f2_c = b_q[FW-1:0];
    assign z1_c = (e1_c == 8'h00);
    assign z2_c = (e2_c == 8'h00);
    assign i1_c = (e1_c == 8'hFF) && (f1_c == '0);
    assign i2_c = (e2_c == 8'hFF) && (f2_c == '0);
    assign n1_c = (e1_c == 8'hFF) && (f1_c != '0);
    assign n2_c = (e2_c == 8'hFF) && (f2_c != '0);

    logic signed [EW-1:0] exp_un_c;
    assign exp_un_c = $signed(EW'(e1_c)) - $signed(EW'(e2_c)) + $signed(EW'(BIAS));

    // Special-case classification, in priority order
    logic        special_c;
    logic [31:0] special_res_c;
    always_comb begin
        special_c     = 1'b1;
        special_res_c = QNAN;
        if (n1_c || n2_c || (z1_c && z2_c) || (i1_c && i2_c)) begin
            special_res_c = QNAN;
        end else if (i1_c || z2_c) begin
            special_res_c = {s_c, 8'hFF, 23'd0};
        end else if (z1_c || i2_c) begin
            special_res_c = {s_c, 31'd0};
        end else begin
            special_c = 1'b0;
        end
    end

    // One restoring-division step
    logic [RW-1:0] div_ext_c, rem_sub_c, rem_sh_c;
    logic          ge_c;
    assign div_ext_c = {1'b0, div_q};
    assign ge_c      = (rem_q >= div_ext_c);
    assign rem_sub_c = ge_c ? (rem_q - div_ext_c) : rem_q;
    assign rem_sh_c  = rem_sub_c << 1;

    // Normalize, round and pack
    logic                 norm_c;
    logic [FW-1:0]        mant_c, mant_r_c;
    logic signed [EW-1:0] exp_n_c, exp_r_c;
    logic [31:0]          pack_res_c;

    assign norm_c  = q_q[QW-1];
    assign mant_c  = norm_c ? q_q[QW-2:2] : q_q[QW-3:1];
    assign exp_n_c = norm_c ? exp_q : (exp_q - 10'sd1);

`ifdef FP_SINGLE_DIVIDER_RNE_EN
    localparam int unsigned SW = FW + 1;
    logic          guard_c, sticky_c, inc_c;
    logic [SW-1:0] sum_c;
    assign guard_c  = norm_c ? q_q[1] : q_q[0];
    assign sticky_c = (norm_c & q_q[0]) | (|rem_q);
    assign inc_c    = guard_c & (sticky_c | mant_c[0]);
    assign sum_c    = {1'b0, mant_c} + SW'(inc_c);
    // Carry-out leaves the fraction at zero and bumps the exponent
    assign mant_r_c = sum_c[FW-1:0];
    assign exp_r_c  = exp_n_c + $signed({{(EW-1){1'b0}}, sum_c[FW]});
`else
    assign mant_r_c = mant_c;
    assign exp_r_c  = exp_n_c;
`endif

    always_comb begin
        if (exp_r_c >= 10'sd255) begin
            pack_res_c = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r_c <= 10'sd0) begin
            pack_res_c = {sign_q, 31'd0};
        end else begin
            pack_res_c = {sign_q, exp_r_c[7:0], mant_r_c};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            res    <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            sign_q <= sign_nxt;
            exp_q  <= exp_nxt;
            rem_q  <= rem_nxt;
            div_q  <= div_nxt;
            q_q    <= q_nxt;
            cnt_q  <= cnt_nxt;
            res    <= res_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        sign_nxt  = sign_q;
        exp_nxt   = exp_q;
        rem_nxt   = rem_q;
        div_nxt   = div_q;
        q_nxt     = q_q;
        cnt_nxt   = cnt_q;
        res_nxt   = res;
        case (state)
            IDLE: begin
                if (ready) begin
                    a_nxt     = op1;
                    b_nxt     = op2;
                    state_nxt = UNPACK;
                end
            end
            UNPACK: begin
                sign_nxt = s_c;
                if (special_c) begin
                    res_nxt   = special_res_c;
                    state_nxt = DONE;
                end else begin
                    exp_nxt   = exp_un_c;
                    rem_nxt   = {1'b0, 1'b1, f1_c};
                    div_nxt   = {1'b1, f2_c};
                    q_nxt     = '0;
                    cnt_nxt   = '0;
                    state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                q_nxt   = {q_q[QW-2:0], ge_c};
                rem_nxt = rem_sh_c;
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_nxt = PACK;
                end
            end
            PACK: begin
                res_nxt   = pack_res_c;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_fp_single_divider.sv
// tb_fp_single_divider: randomized and directed bench for fp_single_divider.
// An integer-arithmetic reference and a start/latency timeline model predict done, busy and res every cycle.
// Honors FP_SINGLE_DIVIDER_RNE_EN in the same way as the design.
module tb_fp_single_divider;

    localparam logic [31:0] QNAN   = 32'h7FC00000;
    localparam int          LAT    = 29;
    localparam int          LAT_SP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [31:0] res;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    fp_single_divider #(.QNAN(QNAN)) dut (
        .clk  (clk),
        .rst  (rst),
        .ready(ready),
        .op1  (op1),
        .op2  (op2),
        .res  (res),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quotient straight from the IEEE rules using integer division
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output bit special);
        logic s;
        int ea, eb, e;
        bit za, zb, ia, ib, na, nb;
        longint unsigned num, den, q, r, mant;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        special = 1'b1;
        if (na || nb || (za && zb) || (ia && ib)) return QNAN;
        if (ia || zb) return {s, 8'hFF, 23'd0};
        if (za || ib) return {s, 31'd0};
        special = 1'b0;
        num = 64'({1'b1, a[22:0]}) << 25;
        den = 64'({1'b1, b[22:0]});
        q   = num / den;
        r   = num % den;
        e   = ea - eb + 127;
        if ((q >> 25) == 64'd0) begin
            q = q << 1;
            e = e - 1;
        end
        mant = (q >> 2) & 64'h7FFFFF;
`ifdef FP_SINGLE_DIVIDER_RNE_EN
        if (q[1] && (q[0] || (r != 64'd0) || mant[0])) mant = mant + 64'd1;
        if (mant == 64'h800000) begin
            mant = 64'd0;
            e    = e + 1;
        end
`else
        if (r == 64'hFFFF_FFFF_FFFF_FFFF) mant = 64'd0;  // keeps r referenced; never true
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(mant)};
    endfunction

    // Random operand biased toward zeros, infinities, NaNs and extreme exponents
    function automatic logic [31:0] rand_fp();
        int          k;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        k = $urandom_range(0, 9);
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case (k)
            0: begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = 23'd0; end
            1: begin e = 8'hFF; f = 23'd0; end
            2: begin e = 8'hFF; f = f | 23'd1; end
            3: e = 8'($urandom_range(1, 6));
            4: e = 8'($urandom_range(249, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, f};
    endfunction

    // Timeline model: accept while idle, done after LAT or LAT_SP cycles, then one DONE cycle
    int          ecount = 0;
    bit          m_active = 1'b0;
    int          m_e0 = 0;
    int          m_len = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res = '0;
    bit          m_sp;
    logic        exp_done, exp_busy;

    always @(posedge clk) begin
        ecount++;
        if (!rst) begin
            m_active = 1'b0;
            m_res    = '0;
        end else if (m_active && ecount == m_e0 + m_len) begin
            m_active = 1'b0;
        end else if (!m_active && ready) begin
            m_active = 1'b1;
            m_e0     = ecount;
            m_pend   = ref_div(op1, op2, m_sp);
            m_len    = m_sp ? LAT_SP : LAT;
        end
        exp_busy = m_active;
        exp_done = m_active && (ecount == m_e0 + m_len - 1);
        if (exp_done) m_res = m_pend;
        #2;
        check("cyc_busy", 32'(busy), 32'(exp_busy));
        check("cyc_done", 32'(done), 32'(exp_done));
        if (!m_active || exp_done) check("cyc_res", res, m_res);
    end

    // Start one operation and wait for its done pulse, checking result and latency
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r,
                          input int exp_lat, input int poke_at, input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        op1   = a;
        op2   = b;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                ready = 1'b0;
                op1   = $urandom;
                op2   = $urandom;
            end
            if (poke_at != 0 && n == poke_at) begin
                ready = 1'b1;
                op1   = 32'h3F800000;
                op2   = 32'h3F800000;
            end
            if (poke_at != 0 && n == poke_at + 1) ready = 1'b0;
            if (done) begin
                seen = 1'b1;
                check({name, "_res"}, res, exp_r);
                check({name, "_lat"}, 32'(n), 32'(exp_lat));
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: actual no done required done", name);
        end
    endtask

    initial begin
        bit          sp;
        logic [31:0] a, b, r;
        int          n_done, first_done, last_done;

        // Pin the reference against hand-computed quotients
        check("ref_5_2", ref_div(32'h40A00000, 32'h40000000, sp), 32'h40200000);
        check("ref_m6_1p5", ref_div(32'hC0C00000, 32'h3FC00000, sp), 32'hC0800000);
`ifdef FP_SINGLE_DIVIDER_RNE_EN
        check("ref_1_3", ref_div(32'h3F800000, 32'h40400000, sp), 32'h3EAAAAAB);
`else
        check("ref_1_3", ref_div(32'h3F800000, 32'h40400000, sp), 32'h3EAAAAAA);
`endif
        check("ref_ovf", ref_div(32'h7F000000, 32'h3E800000, sp), 32'h7F800000);
        check("ref_unf", ref_div(32'h00800000, 32'h40000000, sp), 32'h00000000);

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res", res, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;

        run_op(32'h40A00000, 32'h40000000, 32'h40200000, LAT, 0, "div_5_2");
        run_op(32'hC0C00000, 32'h3FC00000, 32'hC0800000, LAT, 0, "div_m6_1p5");
`ifdef FP_SINGLE_DIVIDER_RNE_EN
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, LAT, 0, "div_1_3");
`else
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, LAT, 0, "div_1_3");
`endif
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, LAT_SP, 0, "x_div_0");
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, LAT_SP, 0, "zero_div_0");
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, LAT_SP, 0, "nan_in");
        run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, LAT, 0, "overflow");
        run_op(32'h00800000, 32'h40000000, 32'h00000000, LAT, 0, "underflow");
        run_op(32'h40A00000, 32'h40000000, 32'h40200000, LAT, 10, "busy_ignore");

        // Reset in the middle of an operation
        @(negedge clk);
        ready = 1'b1;
        op1   = 32'h40A00000;
        op2   = 32'h40000000;
        @(negedge clk);
        ready = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_res", res, 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_op(32'h40A00000, 32'h40000000, 32'h40200000, LAT, 0, "after_rst");

        // ready held high: back-to-back operations with one idle cycle between
        @(negedge clk);
        ready      = 1'b1;
        op1        = 32'h40A00000;
        op2        = 32'h40000000;
        n_done     = 0;
        first_done = 0;
        last_done  = 0;
        for (int n = 1; n <= 95; n++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = n;
                last_done = n;
            end
        end
        ready = 1'b0;
        check("b2b_count", 32'(n_done), 32'd3);
        check("b2b_first", 32'(first_done), 32'(LAT));
        check("b2b_last", 32'(last_done), 32'(LAT + 2 * (LAT + 1)));
        repeat (40) @(negedge clk);

        // Randomized single operations against the reference
        for (int i = 0; i < 250; i++) begin
            a = rand_fp();
            b = rand_fp();
            r = ref_div(a, b, sp);
            run_op(a, b, r, sp ? LAT_SP : LAT, 0, "rand_op");
        end

        // Random ready activity with changing operands; the timeline model checks every cycle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 2) == 0);
            op1   = rand_fp();
            op2   = rand_fp();
        end
        ready = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
